// File: rtl/uvmt_mem_st_rst_seq_gen.sv
// ---------------------------------------------------------------------------
// uvmt_mem_st_rst_seq_gen
//
// Multi-channel reset / clock-enable sequencer for the memory self-test bench.
// Releases NUM_CH active-high channel resets one after another, channel 0
// first. Each channel waits for its own programmable hold interval. Once a
// channel is out of reset it gets a divided clock-enable strobe. A software
// request re-runs the whole release sequence.
//
// Ports:
//   clk         single bench clock, all logic on the rising edge
//   reset       synchronous active-high reset (also restores config)
//   cfg_we      one-cycle config write strobe
//   cfg_ch      channel targeted by the write
//   cfg_hold    hold interval in cycles for cfg_ch (0 behaves as 1)
//   cfg_div     clock-enable divide ratio for cfg_ch (0 behaves as 1)
//   cfg_err     one-cycle pulse after a rejected write
//   sw_rst_req  one-cycle request to restart the reset sequence
//   busy        high while the release sequence is running
//   ch_reset    per-channel active-high reset
//   ch_reset_n  registered bitwise complement of ch_reset
//   ch_clk_en   per-channel divided clock-enable
// ---------------------------------------------------------------------------
module uvmt_mem_st_rst_seq_gen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HOLD = 16,
    parameter int DEFAULT_DIV  = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_hold,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic              sw_rst_req,
    output logic              busy,
    output logic [NUM_CH-1:0] ch_reset,
    output logic [NUM_CH-1:0] ch_reset_n,
    output logic [NUM_CH-1:0] ch_clk_en
);

    typedef enum logic {
        SEQ  = 1'b0,
        IDLE = 1'b1
    } state_t;

    // One extra bit so that NUM_CH itself is representable in the range check.
    localparam logic [CH_W:0]   NUM_CH_V  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_IDX  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] HOLD_RST = CNT_W'(DEFAULT_HOLD);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CH_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  rst_d;
    logic               busy_d;

    logic [CNT_W-1:0]   hold_q   [NUM_CH];
    logic [CNT_W-1:0]   div_q    [NUM_CH];
    logic [CNT_W-1:0]   div_sh_q [NUM_CH];
    logic [CNT_W-1:0]   dcnt_q   [NUM_CH];
    logic [CNT_W-1:0]   eff_div  [NUM_CH];
    logic [NUM_CH-1:0]  div_wrap;

    logic [CNT_W-1:0]   eff_hold;
    logic               cfg_accept;

    // Next-state logic for the release sequencer. A hold of 0 is treated as 1
    // so a channel can never stall the sequence. A restart request while the
    // sequence runs simply rewinds it to channel 0 with a fresh count.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rst_d    = ch_reset;
        busy_d   = busy;
        eff_hold = (hold_q[idx_q] == '0) ? ONE : hold_q[idx_q];

        cfg_accept = cfg_we && (state_q == IDLE) && ({1'b0, cfg_ch} < NUM_CH_V);

        case (state_q)
            SEQ: begin
                if (sw_rst_req) begin
                    rst_d = '1;
                    idx_d = '0;
                    cnt_d = '0;
                end else if (cnt_q == eff_hold - ONE) begin
                    rst_d[idx_q] = 1'b0;
                    cnt_d        = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            IDLE: begin
                if (sw_rst_req) begin
                    rst_d   = '1;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = SEQ;
                end
            end
            default: state_d = SEQ;
        endcase
    end

    // Sequencer state and the reset outputs. ch_reset_n is registered from the
    // same next value so it is always the exact complement of ch_reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEQ;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b1;
            ch_reset   <= '1;
            ch_reset_n <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy       <= busy_d;
            ch_reset   <= rst_d;
            ch_reset_n <= ~rst_d;
        end
    end

    // Configuration registers. Writes land only in IDLE; a write in the same
    // cycle as a restart request is therefore seen by the new sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= HOLD_RST;
                div_q[i]  <= DIV_RST;
            end
        end else begin
            cfg_err <= cfg_we && !cfg_accept;
            if (cfg_accept) begin
                hold_q[cfg_ch] <= cfg_hold;
                div_q[cfg_ch]  <= cfg_div;
            end
        end
    end

    // Effective divide ratio and wrap detect for each channel, taken from the
    // shadow copy so a new ratio only applies from the next wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eff_div[i]  = (div_sh_q[i] == '0) ? ONE : div_sh_q[i];
            div_wrap[i] = (dcnt_q[i] == eff_div[i] - ONE);
        end
    end

    // Per-channel clock-enable dividers. While a channel is held in reset the
    // shadow ratio tracks the programmed one, so every new sequence starts
    // with the current setting.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_clk_en <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dcnt_q[i]   <= '0;
                div_sh_q[i] <= DIV_RST;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_reset[i]) begin
                    ch_clk_en[i] <= 1'b0;
                    dcnt_q[i]    <= '0;
                    div_sh_q[i]  <= div_q[i];
                end else begin
                    ch_clk_en[i] <= (dcnt_q[i] == '0);
                    if (div_wrap[i]) begin
                        dcnt_q[i]   <= '0;
                        div_sh_q[i] <= div_q[i];
                    end else begin
                        dcnt_q[i] <= dcnt_q[i] + ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uvmt_mem_st_rst_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_uvmt_mem_st_rst_seq_gen
//
// Bench for the reset / clock-enable sequencer. A 4-channel instance carries
// the main release-timing and clock-enable checks; a 3-channel instance is
// used for the out-of-range channel write, which a 2-bit cfg_ch can express
// only when NUM_CH is not a power of two.
// ---------------------------------------------------------------------------
module tb_uvmt_mem_st_rst_seq_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_hold;
    logic [15:0] cfg_div;
    logic        cfg_err;
    logic        sw_rst_req;
    logic        busy;
    logic [3:0]  ch_reset;
    logic [3:0]  ch_reset_n;
    logic [3:0]  ch_clk_en;

    logic        cfg3_we;
    logic [1:0]  cfg3_ch;
    logic        cfg3_err;
    logic        sw3_req;
    logic        busy3;
    logic [2:0]  ch3_reset;
    logic [2:0]  ch3_reset_n;
    logic [2:0]  ch3_clk_en;

    typedef struct {
        int         test_id;
        int         k;
        logic [3:0] en;
    } en_vec_t;

    en_vec_t    vecs [$];
    logic [3:0] en_tr  [0:127];
    logic       err_tr [0:127];
    int         rel  [4];
    int         rel3 [3];
    int         bfall;
    int         rn_bad;
    int         vec_cnt = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    uvmt_mem_st_rst_seq_gen #(
        .NUM_CH(4), .CNT_W(16), .DEFAULT_HOLD(16), .DEFAULT_DIV(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_hold(cfg_hold), .cfg_div(cfg_div),
        .cfg_err(cfg_err), .sw_rst_req(sw_rst_req), .busy(busy),
        .ch_reset(ch_reset), .ch_reset_n(ch_reset_n), .ch_clk_en(ch_clk_en)
    );

    uvmt_mem_st_rst_seq_gen #(
        .NUM_CH(3), .CNT_W(16), .DEFAULT_HOLD(16), .DEFAULT_DIV(1)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .cfg_we(cfg3_we), .cfg_ch(cfg3_ch), .cfg_hold(cfg_hold), .cfg_div(cfg_div),
        .cfg_err(cfg3_err), .sw_rst_req(sw3_req), .busy(busy3),
        .ch_reset(ch3_reset), .ch_reset_n(ch3_reset_n), .ch_clk_en(ch3_clk_en)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int id, input int k, input logic [3:0] en);
        en_vec_t v;
        v.test_id = id;
        v.k       = k;
        v.en      = en;
        vecs.push_back(v);
    endtask

    // Drives one cycle of stimulus from a negedge, then returns at the next
    // negedge with strobes dropped.
    task automatic applyStimulus(input logic we, input logic [1:0] ch,
                                 input logic [15:0] hold, input logic [15:0] div,
                                 input logic req, input logic we3,
                                 input logic [1:0] ch3, input logic req3);
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_hold   = hold;
        cfg_div    = div;
        sw_rst_req = req;
        cfg3_we    = we3;
        cfg3_ch    = ch3;
        sw3_req    = req3;
        @(posedge clk);
        @(negedge clk);
        cfg_we     = 1'b0;
        sw_rst_req = 1'b0;
        cfg3_we    = 1'b0;
        sw3_req    = 1'b0;
    endtask

    // Steps cycles k0+1..ncyc after a trigger edge (k = 0), recording the
    // first cycle each reset is seen low plus the enable and error traces.
    task automatic measure(input int k0, input int ncyc);
        for (int i = 0; i < 4; i++) rel[i] = -1;
        for (int i = 0; i < 3; i++) rel3[i] = -1;
        bfall  = -1;
        rn_bad = 0;
        for (int k = k0 + 1; k <= ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            en_tr[k]  = ch_clk_en;
            err_tr[k] = cfg_err;
            for (int i = 0; i < 4; i++)
                if (rel[i] < 0 && !ch_reset[i]) rel[i] = k;
            for (int i = 0; i < 3; i++)
                if (rel3[i] < 0 && !ch3_reset[i]) rel3[i] = k;
            if (bfall < 0 && !busy) bfall = k;
            if (ch_reset_n !== ~ch_reset) rn_bad++;
        end
    endtask

    task automatic check_rel(input string tag, input int e0, input int e1,
                             input int e2, input int e3, input int eb);
        checkOutput({tag, "_rel0"}, rel[0], e0);
        checkOutput({tag, "_rel1"}, rel[1], e1);
        checkOutput({tag, "_rel2"}, rel[2], e2);
        checkOutput({tag, "_rel3"}, rel[3], e3);
        checkOutput({tag, "_busy_fall"}, bfall, eb);
        checkOutput({tag, "_rst_n_cmpl"}, rn_bad, 0);
    endtask

    task automatic run_vectors(input int id, input string tag);
        foreach (vecs[i]) begin
            if (vecs[i].test_id == id)
                checkOutput($sformatf("%s_en_k%0d", tag, vecs[i].k),
                            int'(en_tr[vecs[i].k]), int'(vecs[i].en));
        end
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_ch_reset"},   int'(ch_reset),   15);
        checkOutput({tag, "_ch_reset_n"}, int'(ch_reset_n), 0);
        checkOutput({tag, "_ch_clk_en"},  int'(ch_clk_en),  0);
        checkOutput({tag, "_busy"},       int'(busy),       1);
        checkOutput({tag, "_cfg_err"},    int'(cfg_err),    0);
        checkOutput({tag, "_ch3_reset"},  int'(ch3_reset),  7);
    endtask

    initial begin
        // Defaults: channel i is released 16*(i+1) edges in, enables from +1.
        add_vec(1, 16, 4'b0000); add_vec(1, 17, 4'b0001);
        add_vec(1, 32, 4'b0001); add_vec(1, 33, 4'b0011);
        add_vec(1, 48, 4'b0011); add_vec(1, 49, 4'b0111);
        add_vec(1, 64, 4'b0111); add_vec(1, 65, 4'b1111);
        // ch1 hold 3 div 4: releases 16/19/35/51, ch1 pulses at 20,24,28...
        add_vec(2, 19, 4'b0001); add_vec(2, 20, 4'b0011);
        add_vec(2, 21, 4'b0001); add_vec(2, 23, 4'b0001);
        add_vec(2, 24, 4'b0011); add_vec(2, 36, 4'b0111);
        add_vec(2, 37, 4'b0101); add_vec(2, 52, 4'b1111);
        add_vec(2, 53, 4'b1101);
        // plus ch2 hold 0 div 0: releases 16/19/20/36, ch2 constant from 21.
        add_vec(3, 20, 4'b0011); add_vec(3, 21, 4'b0101);
        add_vec(3, 22, 4'b0101); add_vec(3, 24, 4'b0111);
        add_vec(3, 36, 4'b0111); add_vec(3, 37, 4'b1101);
        add_vec(3, 40, 4'b1111);

        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_hold   = '0;
        cfg_div    = '0;
        sw_rst_req = 1'b0;
        cfg3_we    = 1'b0;
        cfg3_ch    = '0;
        sw3_req    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");

        $display("[TB] default release sequence");
        reset = 1'b0;
        measure(0, 70);
        check_rel("t1", 16, 32, 48, 64, 64);
        run_vectors(1, "t1");
        checkOutput("t1_n3_rel0", rel3[0], 16);
        checkOutput("t1_n3_rel1", rel3[1], 32);
        checkOutput("t1_n3_rel2", rel3[2], 48);

        $display("[TB] out-of-range channel write on 3-channel instance");
        applyStimulus(1'b0, 2'd0, 16'd2, 16'd2, 1'b0, 1'b1, 2'd3, 1'b0);
        checkOutput("t5_range_err_pulse", int'(cfg3_err), 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_range_err_clear", int'(cfg3_err), 0);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("t5_n3_restart", int'(ch3_reset), 7);
        measure(0, 60);
        checkOutput("t5_n3_rel0", rel3[0], 16);
        checkOutput("t5_n3_rel1", rel3[1], 32);
        checkOutput("t5_n3_rel2", rel3[2], 48);

        $display("[TB] ch1 hold 3 div 4");
        applyStimulus(1'b1, 2'd1, 16'd3, 16'd4, 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("t2_cfg_err", int'(cfg_err), 0);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("t2_restart_rst", int'(ch_reset), 15);
        checkOutput("t2_restart_busy", int'(busy), 1);
        measure(0, 60);
        check_rel("t2", 16, 19, 35, 51, 51);
        run_vectors(2, "t2");

        $display("[TB] ch2 hold 0 div 0 written together with restart");
        applyStimulus(1'b1, 2'd2, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("t3_cfg_err", int'(cfg_err), 0);
        checkOutput("t3_restart_rst", int'(ch_reset), 15);
        measure(0, 50);
        check_rel("t3", 16, 19, 20, 36, 36);
        run_vectors(3, "t3");

        $display("[TB] write while busy is rejected");
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd0, 16'd2, 16'd7, 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("t5_busy_err_pulse", int'(cfg_err), 1);
        measure(1, 50);
        checkOutput("t5_busy_err_clear", int'(err_tr[2]), 0);
        check_rel("t5", 16, 19, 20, 36, 36);
        run_vectors(3, "t5");

        $display("[TB] reset mid-sequence after ch0 hold 5");
        applyStimulus(1'b1, 2'd0, 16'd5, 16'd1, 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("t6_cfg_err", int'(cfg_err), 0);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        measure(0, 10);
        checkOutput("t6_hold5_rel0", rel[0], 5);
        checkOutput("t6_hold5_rel1", rel[1], 8);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("t6_reset");
        reset = 1'b0;
        measure(0, 70);
        check_rel("t6", 16, 32, 48, 64, 64);
        run_vectors(1, "t6");

        $display("[TB] restart 20 cycles into the sequence");
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        measure(0, 20);
        checkOutput("t4_pre_rel0", rel[0], 16);
        checkOutput("t4_pre_rel1", rel[1], -1);
        applyStimulus(1'b0, 2'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("t4_restart_rst", int'(ch_reset), 15);
        checkOutput("t4_restart_busy", int'(busy), 1);
        measure(0, 70);
        check_rel("t4", 16, 32, 48, 64, 64);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
